// File: rtl/texture_loader.sv
// Power-up texture loader: burst-reads bird, pipe and base images from SDRAM
// and streams them into the renderer's texture RAMs, cropping base rows to BASE_TEX_W.
module texture_loader #(
  parameter logic [23:0] BIRD_BASE  = 24'h000000,
  parameter int          BIRD_WORDS = 5250,
  parameter logic [23:0] PIPE_BASE  = 24'h002000,
  parameter int          PIPE_WORDS = 4000,
  parameter logic [23:0] BASE_BASE  = 24'h00C000,
  parameter int          BASE_SRC_W = 64,
  parameter int          BASE_TEX_W = 32,
  parameter int          BASE_ROWS  = 150,
  parameter int          BURST_LEN  = 256
) (
  input  logic        bird_load_clk,
  input  logic        rst_n,
  input  logic        i_load_start,
  output logic        o_load_busy,
  output logic        o_load_done,
  output logic        o_rd_req,
  output logic [23:0] o_rd_addr,
  output logic [8:0]  o_rd_len,
  input  logic        i_rd_ack,
  input  logic        i_rd_data_valid,
  input  logic [15:0] i_rd_data,
  output logic [15:0] o_load_data,
  output logic        o_bird_load_en,
  output logic [12:0] o_bird_load_addr,
  output logic        o_pipe_load_en,
  output logic [15:0] o_pipe_load_addr,
  output logic        o_base_load_en,
  output logic [13:0] o_base_load_addr
);
  localparam int BASE_WORDS = BASE_SRC_W * BASE_ROWS;
  localparam int CW = $clog2(BASE_SRC_W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_NEXT, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_region;
  logic [23:0]   r_wc;
  logic [8:0]    r_bc, r_len;
  logic [CW-1:0] r_col;
  logic [13:0]   r_row;
  logic          r_busy, r_done;
  logic [15:0]   r_load_data;
  logic          r_bird_en, r_pipe_en, r_base_en;
  logic [12:0]   r_bird_addr;
  logic [15:0]   r_pipe_addr;
  logic [13:0]   r_base_addr;

  logic [23:0]   w_words, w_base, w_rem;
  logic [8:0]    w_len;
  logic          w_last_beat, w_region_end;

  function automatic logic [23:0] words_of(input logic [1:0] rg);
    case (rg)
      2'd0:    return 24'(BIRD_WORDS);
      2'd1:    return 24'(PIPE_WORDS);
      default: return 24'(BASE_WORDS);
    endcase
  endfunction

  function automatic logic [23:0] base_of(input logic [1:0] rg);
    case (rg)
      2'd0:    return BIRD_BASE;
      2'd1:    return PIPE_BASE;
      default: return BASE_BASE;
    endcase
  endfunction

  assign w_words      = words_of(r_region);
  assign w_base       = base_of(r_region);
  assign w_rem        = w_words - r_wc;
  assign w_len        = (w_rem > 24'(BURST_LEN)) ? 9'(BURST_LEN) : w_rem[8:0];
  assign w_last_beat  = i_rd_data_valid && (r_bc + 9'd1 == r_len);
  assign w_region_end = (r_wc + 24'd1 == w_words);

  always_ff @(posedge bird_load_clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    o_rd_req  = 1'b0;
    o_rd_addr = '0;
    o_rd_len  = '0;
    case (r_state)
      S_IDLE, S_DONE:
        if (i_load_start) w_next = (words_of(2'd0) == 24'd0) ? S_NEXT : S_REQ;
      S_REQ: begin
        o_rd_req  = 1'b1;
        o_rd_addr = w_base + r_wc;
        o_rd_len  = w_len;
        if (i_rd_ack) w_next = S_DATA;
      end
      S_DATA:
        if (w_last_beat) w_next = w_region_end ? S_NEXT : S_REQ;
      S_NEXT:
        // empty regions fall through NEXT again without touching SDRAM
        if (r_region == 2'd2)                          w_next = S_DONE;
        else if (words_of(r_region + 2'd1) == 24'd0)   w_next = S_NEXT;
        else                                           w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge bird_load_clk or negedge rst_n)
    if (!rst_n) begin
      r_region    <= '0;
      r_wc        <= '0;
      r_bc        <= '0;
      r_len       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_data <= '0;
      r_bird_en   <= 1'b0;
      r_pipe_en   <= 1'b0;
      r_base_en   <= 1'b0;
      r_bird_addr <= '0;
      r_pipe_addr <= '0;
      r_base_addr <= '0;
    end else begin
      r_bird_en <= 1'b0;
      r_pipe_en <= 1'b0;
      r_base_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE:
          if (i_load_start) begin
            r_region <= '0;
            r_wc     <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
          end
        S_REQ:
          if (i_rd_ack) begin
            r_bc  <= '0;
            r_len <= w_len;
          end
        S_DATA:
          if (i_rd_data_valid) begin
            r_wc        <= r_wc + 24'd1;
            r_bc        <= r_bc + 9'd1;
            r_load_data <= i_rd_data;
            case (r_region)
              2'd0: begin r_bird_en <= 1'b1; r_bird_addr <= r_wc[12:0]; end
              2'd1: begin r_pipe_en <= 1'b1; r_pipe_addr <= r_wc[15:0]; end
              default: begin
                if (r_col < CW'(BASE_TEX_W)) begin
                  r_base_en   <= 1'b1;
                  r_base_addr <= 14'(r_row * 14'(BASE_TEX_W)) + 14'(r_col);
                end
                if (r_col == CW'(BASE_SRC_W - 1)) begin
                  r_col <= '0;
                  r_row <= r_row + 14'd1;
                end else begin
                  r_col <= r_col + CW'(1);
                end
              end
            endcase
          end
        S_NEXT: begin
          r_region <= r_region + 2'd1;
          r_wc     <= '0;
          r_col    <= '0;
          r_row    <= '0;
          if (r_region == 2'd2) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end

  assign o_load_busy      = r_busy;
  assign o_load_done      = r_done;
  assign o_load_data      = r_load_data;
  assign o_bird_load_en   = r_bird_en;
  assign o_bird_load_addr = r_bird_addr;
  assign o_pipe_load_en   = r_pipe_en;
  assign o_pipe_load_addr = r_pipe_addr;
  assign o_base_load_en   = r_base_en;
  assign o_base_load_addr = r_base_addr;
endmodule

// File: tb/tb_texture_loader.sv
// Bench for texture_loader: randomized SDRAM responder plus a list-based model of
// the expected request sequence and texture writes, checked every cycle.
module tb_texture_loader;
  logic        bird_load_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_load_start = 1'b0, i_rd_ack = 1'b0, i_rd_data_valid = 1'b0;
  logic [15:0] i_rd_data = '0;
  logic        o_load_busy, o_load_done, o_rd_req;
  logic [23:0] o_rd_addr;
  logic [8:0]  o_rd_len;
  logic [15:0] o_load_data;
  logic        o_bird_load_en, o_pipe_load_en, o_base_load_en;
  logic [12:0] o_bird_load_addr;
  logic [15:0] o_pipe_load_addr;
  logic [13:0] o_base_load_addr;

  texture_loader dut (
    .bird_load_clk(bird_load_clk), .rst_n(rst_n), .i_load_start(i_load_start),
    .o_load_busy(o_load_busy), .o_load_done(o_load_done),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
    .i_rd_ack(i_rd_ack), .i_rd_data_valid(i_rd_data_valid), .i_rd_data(i_rd_data),
    .o_load_data(o_load_data),
    .o_bird_load_en(o_bird_load_en), .o_bird_load_addr(o_bird_load_addr),
    .o_pipe_load_en(o_pipe_load_en), .o_pipe_load_addr(o_pipe_load_addr),
    .o_base_load_en(o_base_load_en), .o_base_load_addr(o_base_load_addr)
  );

  always #5 bird_load_clk = ~bird_load_clk;

  typedef struct {bit kept; int port; int addr; logic [15:0] data;} wr_t;
  typedef struct {int addr; int len;} rq_t;

  wr_t exp_q[$];
  rq_t req_q[$];
  int  n_chk = 0, n_err = 0;
  int  cnt_b = 0, cnt_p = 0, cnt_s = 0;
  logic [15:0] salt = 16'h1234;
  bit  real_w = 1'b0, s_vld = 1'b0, s_real = 1'b0, chk_on = 1'b0, pend = 1'b0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mem(input int a);
    logic [31:0] t;
    t = a * 32'd40503;
    return t[15:0] ^ t[31:16] ^ salt;
  endfunction

  task automatic add_region(input int port, input int base, input int words);
    for (int off = 0; off < words; off += 256)
      req_q.push_back('{base + off, (words - off < 256) ? words - off : 256});
    for (int i = 0; i < words; i++) begin
      wr_t e;
      e.port = port;
      e.data = mem(base + i);
      if (port == 2) begin
        e.kept = (i % 64) < 32;
        e.addr = (i / 64) * 32 + (i % 64);
      end else begin
        e.kept = 1'b1;
        e.addr = i;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic build_exp();
    exp_q.delete();
    req_q.delete();
    salt = 16'($urandom);
    add_region(0, 'h000000, 5250);
    add_region(1, 'h002000, 4000);
    add_region(2, 'h00C000, 9600);
  endtask

  always @(posedge bird_load_clk) begin
    s_vld  <= i_rd_data_valid;
    s_real <= real_w;
  end

  // Per-cycle write-port check: every word sampled by the DUT maps to one model entry
  always @(negedge bird_load_clk) begin
    int  n_en, aa;
    bit  hit;
    wr_t e;
    if (rst_n && chk_on) begin
      n_en = int'(o_bird_load_en) + int'(o_pipe_load_en) + int'(o_base_load_en);
      cnt_b += int'(o_bird_load_en);
      cnt_p += int'(o_pipe_load_en);
      cnt_s += int'(o_base_load_en);
      chk(n_en <= 1, "one_hot_en", n_en, 1);
      if (pend) begin
        chk(o_load_done && !o_load_busy, "done_rise", o_load_done, 1);
        pend = 1'b0;
      end
      if (s_vld && s_real) begin
        if (exp_q.size() == 0) chk(1'b0, "extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (e.kept) begin
            case (e.port)
              0:       begin hit = o_bird_load_en; aa = int'(o_bird_load_addr); end
              1:       begin hit = o_pipe_load_en; aa = int'(o_pipe_load_addr); end
              default: begin hit = o_base_load_en; aa = int'(o_base_load_addr); end
            endcase
            chk(hit && n_en == 1, "wr_en", int'(hit), 1);
            chk(aa == e.addr, "wr_addr", aa, e.addr);
            chk(o_load_data == e.data, "wr_data", o_load_data, e.data);
          end else begin
            chk(n_en == 0, "crop_no_en", n_en, 0);
          end
          if (exp_q.size() == 0) begin
            chk(!o_load_done && o_load_busy, "done_early", o_load_done, 0);
            pend = 1'b1;
          end
        end
      end else begin
        chk(n_en == 0, "spurious_en", n_en, 0);
      end
    end
  end

  task automatic pulse_start();
    @(posedge bird_load_clk); #1;
    i_load_start = 1'b1;
    @(posedge bird_load_clk); #1;
    i_load_start = 1'b0;
    chk(o_load_busy && !o_load_done, "busy_rise", o_load_busy, 1);
  endtask

  task automatic run_load(input int ack_dly, input int gap_pct, input int abort_at, input int start_at);
    int delivered = 0;
    while (req_q.size() > 0) begin
      int   budget = 0;
      int   a0, l0;
      rq_t  r;
      while (!o_rd_req) begin
        @(posedge bird_load_clk); #1;
        budget++;
        if (budget > 50) begin chk(1'b0, "req_timeout", 0, 1); return; end
      end
      a0 = int'(o_rd_addr);
      l0 = int'(o_rd_len);
      r = req_q.pop_front();
      chk(a0 == r.addr, "req_addr", a0, r.addr);
      chk(l0 == r.len, "req_len", l0, r.len);
      for (int d = 0; d < ack_dly; d++) begin
        @(posedge bird_load_clk); #1;
        chk(o_rd_req && int'(o_rd_addr) == a0 && int'(o_rd_len) == l0, "req_hold", int'(o_rd_addr), a0);
      end
      i_rd_ack = 1'b1;
      @(posedge bird_load_clk); #1;
      i_rd_ack = 1'b0;
      chk(!o_rd_req, "req_drop", o_rd_req, 0);
      for (int k = 0; k < l0; k++) begin
        while ($urandom_range(99) < gap_pct) begin
          @(posedge bird_load_clk); #1;
        end
        i_rd_data_valid = 1'b1;
        i_rd_data = mem(a0 + k);
        real_w = 1'b1;
        i_load_start = (start_at > 0 && delivered == start_at);
        @(posedge bird_load_clk); #1;
        i_rd_data_valid = 1'b0;
        real_w = 1'b0;
        i_load_start = 1'b0;
        delivered++;
        if (abort_at > 0 && delivered == abort_at) return;
      end
    end
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!o_load_done && budget < 20) begin
      @(posedge bird_load_clk); #1;
      budget++;
    end
    chk(o_load_done == 1'b1, "done_timeout", o_load_done, 1);
    chk(exp_q.size() == 0, "words_left", exp_q.size(), 0);
    chk(cnt_b == 5250, "bird_count", cnt_b, 5250);
    chk(cnt_p == 4000, "pipe_count", cnt_p, 4000);
    chk(cnt_s == 4800, "base_count", cnt_s, 4800);
  endtask

  task automatic clear_counts();
    cnt_b = 0; cnt_p = 0; cnt_s = 0;
  endtask

  initial begin
    int kept;
    repeat (3) @(posedge bird_load_clk);
    #1;
    chk({o_load_busy, o_load_done, o_rd_req, o_bird_load_en, o_pipe_load_en, o_base_load_en} == 6'd0,
        "reset_ctrl", {o_load_busy, o_load_done, o_rd_req}, 0);
    chk(o_rd_addr == 24'd0 && o_rd_len == 9'd0, "reset_rd", o_rd_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge bird_load_clk);
    #1;

    build_exp();
    chk(req_q.size() == 75, "model_nreq", req_q.size(), 75);
    chk(req_q[19].len == 256 && req_q[20].addr == 'h1400, "model_bird_last_addr", req_q[20].addr, 'h1400);
    chk(req_q[20].len == 130, "model_bird_last_len", req_q[20].len, 130);
    chk(req_q[21].addr == 'h2000 && req_q[36].addr == 'h2F00, "model_pipe_last_addr", req_q[36].addr, 'h2F00);
    chk(req_q[36].len == 160, "model_pipe_last_len", req_q[36].len, 160);
    chk(exp_q[9250 + 64].kept && exp_q[9250 + 64].addr == 32, "model_base64", exp_q[9250 + 64].addr, 32);
    chk(exp_q[9250 + 95].kept && exp_q[9250 + 95].addr == 63, "model_base95", exp_q[9250 + 95].addr, 63);
    chk(!exp_q[9250 + 32].kept && !exp_q[9250 + 63].kept, "model_crop", exp_q[9250 + 32].kept, 0);
    kept = 0;
    for (int i = 9250; i < exp_q.size(); i++) kept += int'(exp_q[i].kept);
    chk(kept == 4800, "model_base_kept", kept, 4800);

    // load 1: immediate ack, continuous data, ignored start pulse mid-burst
    chk_on = 1'b1;
    clear_counts();
    pulse_start();
    run_load(0, 0, 0, 1000);
    wait_done();

    // load 2: restart from DONE, delayed ack and gapped data
    build_exp();
    chk(o_load_done && !o_load_busy, "done_level", o_load_done, 1);
    clear_counts();
    pulse_start();
    run_load(10, 20, 0, 0);
    wait_done();

    // load 3: asynchronous reset in the middle of a pipe burst
    build_exp();
    clear_counts();
    pulse_start();
    run_load(0, 0, 5250 + 1000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk({o_load_busy, o_load_done, o_rd_req, o_rd_addr, o_rd_len} == 36'd0, "rst_ctrl", o_rd_addr, 0);
    chk({o_load_data, o_bird_load_en, o_pipe_load_en, o_base_load_en} == 19'd0, "rst_wr", o_load_data, 0);
    chk({o_bird_load_addr, o_pipe_load_addr, o_base_load_addr} == 43'd0, "rst_addr", o_pipe_load_addr, 0);
    exp_q.delete();
    req_q.delete();
    @(posedge bird_load_clk); #1;
    @(posedge bird_load_clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      i_rd_data_valid = 1'b1;
      i_rd_data = 16'($urandom);
      @(posedge bird_load_clk); #1;
    end
    i_rd_data_valid = 1'b0;
    repeat (3) @(posedge bird_load_clk);
    #1;
    chk(!o_load_busy && !o_load_done && !o_rd_req, "idle_after_stray", o_load_busy, 0);

    // load 4: fresh load after reset starts again at bird address 0
    build_exp();
    clear_counts();
    pulse_start();
    chk(o_rd_req && o_rd_addr == 24'd0, "restart_addr", o_rd_addr, 0);
    run_load(0, 0, 0, 0);
    wait_done();

    repeat (3) @(posedge bird_load_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #990000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/texture_loader.md
# texture_loader

Burst-read sequencer feeding the sprite renderer's texture RAMs at power-up. On `load_start` it reads three texture images (bird, pipe, base) in that order from SDRAM through a single-outstanding burst-read port. It demultiplexes the returned words onto the renderer's `bird_load_*`, `pipe_load_*` and `base_load_*` write ports, which share one data bus. The base image is column-cropped from 64 to 32 pixels while streaming, so the renderer stores a packed 32-wide texture.

## Interface
Parameters:
- `BIRD_BASE`, 24'h000000: SDRAM word address of the bird image (3 frames, 50x35 each).
- `BIRD_WORDS`, 5250: words in the bird image.
- `PIPE_BASE`, 24'h002000: SDRAM word address of the pipe image.
- `PIPE_WORDS`, 4000: pipe words to fetch (first 50 rows of the 80-wide image).
- `BASE_BASE`, 24'h00C000: SDRAM word address of the base image.
- `BASE_SRC_W`, 64: source base row width.
- `BASE_TEX_W`, 32: stored base row width; power of 2, no larger than `BASE_SRC_W`.
- `BASE_ROWS`, 150: base image rows.
- `BURST_LEN`, 256: maximum words per read request.

Ports:
- **Clock and reset:** reset `rst_n`, asynchronous, active-low; clock `bird_load_clk`.
- **Control:**
  - `load_start`, in, 1: one-cycle start pulse.
  - `load_busy`, out, 1: a load is in progress.
  - `load_done`, out, 1: level, set when all three images are written.
- **SDRAM read port:**
  - `rd_req`, out, 1: burst request.
  - `rd_addr`, out, 24: burst start address.
  - `rd_len`, out, 9: burst length in words, 1..`BURST_LEN`.
  - `rd_ack`, in, 1: request accepted.
  - `rd_data_valid`, in, 1: one returned word per cycle when high.
  - `rd_data`, in, 16: returned word.
- **Texture write ports:**
  - `load_data`, out, 16: shared write data.
  - `bird_load_en`, out, 1; `bird_load_addr`, out, 13.
  - `pipe_load_en`, out, 1; `pipe_load_addr`, out, 16.
  - `base_load_en`, out, 1; `base_load_addr`, out, 14.

## Operation
- **States:** IDLE, REQ, DATA, NEXT, DONE.
- **Region index:** 0 = bird, 1 = pipe, 2 = base. Base source word count is `BASE_SRC_W*BASE_ROWS` (9600).
- **IDLE:**
  - On `load_start`: region=0, word count `wc`=0, clear `load_done`, set `load_busy`, go to REQ.
  - `load_start` is ignored in every state other than IDLE and DONE.
- **REQ:**
  - `rd_req`=1, `rd_addr`=region_base+`wc`, `rd_len`=min(`BURST_LEN`, region_words-`wc`).
  - These outputs hold stable until `rd_ack` is sampled high, then go to DATA. `rd_req` drops the following cycle.
- **DATA:**
  - Each `rd_data_valid` increments `wc` and a burst counter.
  - When the burst counter reaches `rd_len`: if `wc`==region_words go to NEXT, else go to REQ.
  - `rd_data_valid` outside DATA is ignored.
- **NEXT:**
  - region+1 and `wc`=0.
  - If region was 2, go to DONE.
  - A region with 0 words is skipped without issuing any request.
- **DONE:** `load_done`=1, `load_busy`=0. A new `load_start` restarts the load, returning to IDLE behaviour.
- **Bird and pipe write mapping:** for each valid word, assert the region's `_load_en` with addr=`wc`, using the pre-increment value.
- **Base write mapping:**
  - Track source column `col` (0..`BASE_SRC_W`-1) and row `row`.
  - Write only when `col` < `BASE_TEX_W`, to `base_load_addr` = `row*BASE_TEX_W`+`col`.
  - `col` wraps at `BASE_SRC_W`, incrementing `row`.
  - Cropped words produce no enable.
- **Enables:** at most one `_load_en` is high per cycle. `load_data` = the registered `rd_data`.
- **Reset:** asynchronous reset at any point, including mid-burst, forces IDLE, all outputs 0, and all counters 0. Any in-flight SDRAM data after reset is ignored because the state is IDLE.

## Timing
- Write ports are registered: a word valid at cycle N appears as `_load_en`/addr/`load_data` at N+1, as a single-cycle pulse per word.
- Back-to-back `rd_data_valid` gives back-to-back enables; there is no throttling.
- The first data word may arrive no earlier than the cycle after `rd_ack`.
- For the final word of base valid at cycle N: last enable at N+1 (if that column is kept); `load_done` rises and `load_busy` falls at N+2.
- `load_busy` rises the cycle after `load_start`.
- Address arithmetic is 24-bit and unsigned, with no wrap. `rd_len` never exceeds the remaining words in the region.

## Test plan
- **Bird bursts:** full load with a 1-cycle ack and continuous data. Bird uses 21 requests: 20 of length 256, the last of length 130 at `rd_addr` 0x001400. `bird_load_en` fires 5250 times with addr 0..5249.
- **Pipe bursts:** pipe uses 16 requests at 0x002000 + k*256, the last with length 160. `pipe_load_addr` runs 0..3999.
- **Base crop:** base source 9600 words yields exactly 4800 `base_load_en` pulses. Source word 64 (row 1, col 0) writes addr 32. Source word 95 writes addr 63. Source words 32..63 produce no enable.
- **Handshake hold:** `rd_ack` delayed 10 cycles with gapped `rd_data_valid`. `rd_req`/`rd_addr`/`rd_len` stay stable until ack, and the enable count is unchanged. `load_done` rises 2 cycles after the last valid.
- **Reset mid-burst and stray data:** `rst_n` low mid-pipe burst gives all outputs 0. `rd_data_valid` pulses while IDLE produce no enables. A new `load_start` restarts from bird addr 0.
- **Start rules:** `load_start` pulsed during DATA is ignored. `load_start` pulsed in DONE clears `load_done` and reloads.
